// File: rtl/timebase_pkg.sv
// Shared types and constants for the timebase controller.
package timebase_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LOAD  = 2'd3
  } state_t;

  localparam int unsigned MIN_DIV = 2;

  // RUN and LOAD both advance the divide counter.
  function automatic logic run_like(input state_t s);
    return (s == RUN) || (s == LOAD);
  endfunction

endpackage

// File: rtl/timebase_div_cnt.sv
// Divide counter: counts 0..div-1 while enabled, synchronous clear.
// cnt_next exposes the value the counter takes at the next edge.
module timebase_div_cnt #(
  parameter int unsigned DIV_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic [DIV_W-1:0] cnt,
  output logic [DIV_W-1:0] cnt_next,
  output logic             tc
);

  // Terminal count; '>=' recovers if the divisor shrank while the count was frozen.
  always_comb begin
    tc       = (cnt >= (div - DIV_W'(1)));
    cnt_next = cnt;
    if (clr)
      cnt_next = '0;
    else if (en)
      cnt_next = tc ? '0 : cnt + DIV_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else
      cnt <= cnt_next;
  end

endmodule

// File: rtl/timebase_ctrl.sv
// Run/pause/stop timebase controller with tick-aligned divisor updates.
// Optional alarm compare enabled by defining TIMEBASE_ALARM_EN.
module timebase_ctrl
  import timebase_pkg::*;
#(
  parameter int unsigned DIV_W   = 27,
  parameter int unsigned DEF_DIV = 100_000_000,
  parameter int unsigned SEC_W   = 17,
  parameter int unsigned SEC_MAX = 86399
) (
  input  logic             clk_100M,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
`ifdef TIMEBASE_ALARM_EN
  input  logic             alarm_set,
  input  logic [SEC_W-1:0] alarm_sec,
  output logic             alarm,
`endif
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             tick_1s,
  output logic             clk_1s,
  output logic [SEC_W-1:0] sec_cnt,
  output logic             sec_wrap,
  output logic             busy
);

  state_t           state, state_nx;
  logic [DIV_W-1:0] div_reg, div_eff, pend_div, pend_val, raw_div, new_div;
  logic [DIV_W-1:0] div_cnt, cnt_next;
  logic [SEC_W-1:0] sec_inc;
  logic             pend_q, pend_any, tc, cnt_en, tick_edge, too_small, sec_last;

  timebase_div_cnt #(.DIV_W(DIV_W)) u_div_cnt (
    .clk      (clk_100M),
    .rst      (rst),
    .en       (cnt_en),
    .clr      (stop),
    .div      (div_eff),
    .cnt      (div_cnt),
    .cnt_next (cnt_next),
    .tc       (tc)
  );

  // Next state, config handshake and effective divisor.
  // In LOAD the pending divisor already governs the period it starts.
  always_comb begin
    state_nx  = state;
    pend_any  = pend_q | cfg_valid;
    pend_val  = pend_q ? pend_div : cfg_div;
    raw_div   = (state == LOAD) ? pend_val : cfg_div;
    too_small = (raw_div < DIV_W'(MIN_DIV));
    new_div   = too_small ? DIV_W'(MIN_DIV) : raw_div;
    div_eff   = (state == LOAD) ? new_div : div_reg;
    cfg_ready = 1'b0;

    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (pause) state_nx = PAUSE;
               else if (pend_any && tc) state_nx = LOAD;
      PAUSE:   if (start) state_nx = RUN;
      LOAD:    state_nx = RUN;
      default: state_nx = IDLE;
    endcase
    if (stop) state_nx = IDLE;

    cnt_en    = run_like(state) && run_like(state_nx);
    tick_edge = cnt_en && tc;
    sec_last  = (sec_cnt == SEC_W'(SEC_MAX));
    sec_inc   = sec_last ? '0 : sec_cnt + SEC_W'(1);

    if (!rst) begin
      if (state == IDLE || state == PAUSE)
        cfg_ready = cfg_valid;
      else if (state == LOAD)
        cfg_ready = !stop;
    end
  end

  assign busy = run_like(state);

  // State register.
  always_ff @(posedge clk_100M) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Divisor register, pending request latch and sticky clamp flag.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      div_reg  <= DIV_W'(DEF_DIV);
      pend_q   <= 1'b0;
      pend_div <= '0;
      cfg_err  <= 1'b0;
    end else begin
      if (cfg_ready) begin
        div_reg <= new_div;
        if (too_small) cfg_err <= 1'b1;
      end
      if (stop || cfg_ready)
        pend_q <= 1'b0;
      else if (state == RUN && cfg_valid && !pend_q) begin
        pend_q   <= 1'b1;
        pend_div <= cfg_div;
      end
      if (stop) cfg_err <= 1'b0;
    end
  end

  // Tick, seconds count and clk_1s level, all decided on the upcoming state.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      tick_1s  <= 1'b0;
      sec_wrap <= 1'b0;
      sec_cnt  <= '0;
      clk_1s   <= 1'b0;
    end else begin
      tick_1s  <= tick_edge;
      sec_wrap <= tick_edge && sec_last;
      if (stop)
        sec_cnt <= '0;
      else if (tick_edge)
        sec_cnt <= sec_inc;
      if (run_like(state_nx))
        clk_1s <= (cnt_next < (div_eff >> 1));
      else if (state_nx == IDLE)
        clk_1s <= 1'b0;
    end
  end

`ifdef TIMEBASE_ALARM_EN
  logic             armed;
  logic [SEC_W-1:0] alarm_cmp;

  // One-shot alarm on the tick that reaches the armed compare value.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      armed     <= 1'b0;
      alarm_cmp <= '0;
      alarm     <= 1'b0;
    end else begin
      alarm <= 1'b0;
      if (stop)
        armed <= 1'b0;
      else if (alarm_set) begin
        alarm_cmp <= alarm_sec;
        armed     <= 1'b1;
      end else if (tick_edge && armed && sec_inc == alarm_cmp) begin
        alarm <= 1'b1;
        armed <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_timebase_ctrl.sv
// Directed bench for timebase_ctrl (DEF_DIV=10, SEC_MAX=3) with a tick scoreboard.
module tb_timebase_ctrl;

  localparam int unsigned DIV_W = 27;
  localparam int unsigned SEC_W = 17;

  logic             clk = 1'b0;
  logic             rst, start, pause, stop, cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready, cfg_err, tick_1s, clk_1s, sec_wrap, busy;
  logic [SEC_W-1:0] sec_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int c;
    int sec;
    int wrap;
  } exp_t;
  exp_t q[$];

  timebase_ctrl #(
    .DIV_W   (DIV_W),
    .DEF_DIV (10),
    .SEC_W   (SEC_W),
    .SEC_MAX (3)
  ) dut (
    .clk_100M  (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .tick_1s   (tick_1s),
    .clk_1s    (clk_1s),
    .sec_cnt   (sec_cnt),
    .sec_wrap  (sec_wrap),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_tick(input int c, input int sec, input int wrap);
    exp_t e;
    e.c = c; e.sec = sec; e.wrap = wrap;
    q.push_back(e);
  endtask

  // Scoreboard: every observed tick must match the oldest expected one.
  always @(negedge clk) begin
    if (tick_1s === 1'b1) begin
      chk("tick_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("tick_cycle", cyc, e.c);
        chk("tick_sec", sec_cnt, e.sec);
        chk("tick_wrap", sec_wrap, e.wrap);
      end
    end else begin
      chk("wrap_without_tick", sec_wrap, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int e0, r0, s0, t0, n;
    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
    cfg_valid = 1'b0; cfg_div = '0;
    cyc_wait(2);
    chk("rst_tick", tick_1s, 0);
    chk("rst_clk1s", clk_1s, 0);
    chk("rst_sec", sec_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst = 1'b0;
    cyc_wait(1);

    // Basic run: ticks every 10 cycles, 5 high / 5 low, wrap on the 4th tick.
    start = 1'b1; cyc_wait(1); start = 1'b0;
    e0 = cyc;
    push_tick(e0 + 10, 1, 0);
    push_tick(e0 + 20, 2, 0);
    push_tick(e0 + 30, 3, 0);
    push_tick(e0 + 40, 0, 1);
    chk("run_busy", busy, 1);
    for (int k = 0; k < 20; k++) begin
      chk("clk1s_shape", clk_1s, ((k % 10) < 5) ? 1 : 0);
      cyc_wait(1);
    end
    cyc_wait(22);
    chk("sec_after_wrap", sec_cnt, 0);

    // Pause at div_cnt=6, hold, resume: 4 cycles left in the period.
    cyc_wait(4);
    pause = 1'b1; cyc_wait(1); pause = 1'b0;
    chk("pause_busy", busy, 0);
    chk("pause_clk1s", clk_1s, 0);
    cyc_wait(6);
    chk("pause_sec_frozen", sec_cnt, 0);
    start = 1'b1; cyc_wait(1); start = 1'b0;
    r0 = cyc;
    push_tick(r0 + 4, 1, 0);
    push_tick(r0 + 14, 2, 0);
    push_tick(r0 + 18, 3, 0);
    push_tick(r0 + 22, 0, 1);
    push_tick(r0 + 26, 1, 0);

    // Divisor change to 4 requested at div_cnt=2; accepted in the LOAD cycle.
    cyc_wait(6);
    cfg_valid = 1'b1; cfg_div = DIV_W'(4);
    n = 0;
    while (cfg_ready !== 1'b1 && n < 20) begin
      cyc_wait(1);
      n++;
    end
    chk("cfg_ready_cycle", cyc, r0 + 14);
    cfg_valid = 1'b0;
    cyc_wait(1);
    chk("new_period_hi", clk_1s, 1);
    cyc_wait(1);
    chk("new_period_lo", clk_1s, 0);
    chk("cfg_err_clear", cfg_err, 0);
    cyc_wait(11);

    // stop+pause+start together mid-period: stop wins.
    stop = 1'b1; pause = 1'b1; start = 1'b1;
    cyc_wait(1);
    stop = 1'b0; pause = 1'b0; start = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_sec", sec_cnt, 0);
    chk("stop_clk1s", clk_1s, 0);
    cyc_wait(3);

    // Divisor retained across stop; then reset mid-period.
    start = 1'b1; cyc_wait(1); start = 1'b0;
    s0 = cyc;
    push_tick(s0 + 4, 1, 0);
    cyc_wait(6);
    rst = 1'b1; cyc_wait(1); rst = 1'b0;
    chk("rst2_tick", tick_1s, 0);
    chk("rst2_clk1s", clk_1s, 0);
    chk("rst2_sec", sec_cnt, 0);
    chk("rst2_wrap", sec_wrap, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_cfg_ready", cfg_ready, 0);

    // Clamp in IDLE: divisor 1 stored as 2, sticky error.
    cfg_valid = 1'b1; cfg_div = DIV_W'(1);
    #1;
    chk("idle_cfg_ready", cfg_ready, 1);
    cyc_wait(1);
    cfg_valid = 1'b0;
    chk("clamp_err", cfg_err, 1);
    start = 1'b1; cyc_wait(1); start = 1'b0;
    t0 = cyc;
    push_tick(t0 + 2, 1, 0);
    push_tick(t0 + 4, 2, 0);
    push_tick(t0 + 6, 3, 0);
    push_tick(t0 + 8, 0, 1);
    chk("div2_hi", clk_1s, 1);
    cyc_wait(1);
    chk("div2_lo", clk_1s, 0);
    cyc_wait(8);
    stop = 1'b1; cyc_wait(1); stop = 1'b0;
    chk("stop_clears_err", cfg_err, 0);
    cyc_wait(2);

    chk("ticks_outstanding", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
